// File: rtl/a2p_read_request_mapper.sv
// AXI AR -> PCIe MRd header mapper for the AXI slave bridge TX path.
// Allocates a free tag in the request recorder and emits a 3DW/4DW header.
module a2p_read_request_mapper #(
    parameter int          ID_WIDTH     = 8,
    parameter int          ADDR_WIDTH   = 64,
    parameter int          TAG_WIDTH    = 4,
    parameter logic [15:0] REQUESTER_ID = 16'h0100
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [ID_WIDTH-1:0]   ARID,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    output logic [TAG_WIDTH-1:0]  req_rd_addr,
    input  logic [ID_WIDTH:0]     req_rd_data,
    output logic                  req_wr_en,
    output logic [TAG_WIDTH-1:0]  req_wr_addr,
    output logic [ID_WIDTH:0]     req_wr_data,
    output logic                  hdr_valid,
    input  logic                  hdr_ready,
    output logic [127:0]          hdr,
    output logic                  hdr_4dw,
    output logic                  tags_full,
    output logic                  err_oversize
);

    localparam int DEPTH = 2 ** TAG_WIDTH;
    localparam logic [TAG_WIDTH:0] CNT_FULL = (TAG_WIDTH + 1)'(DEPTH);
    localparam logic [TAG_WIDTH:0] CNT_LAST = (TAG_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_ALLOC, S_SEND} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_arready;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [12:0]           r_end;
    logic [TAG_WIDTH-1:0]  r_ptr;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [TAG_WIDTH-1:0]  r_next_tag;
    logic [TAG_WIDTH:0]    r_cnt;
    logic                  r_tags_full;
    logic                  r_err;
    logic [127:0]          r_hdr;
    logic                  r_hdr_4dw;

    logic        w_accept;
    logic [16:0] w_bytes;
    logic [16:0] w_end_in;
    logic        w_over;
    logic        w_free;
    logic        w_unused_rd_id;

    assign w_accept = ARVALID && r_arready;
    assign w_bytes  = ({9'd0, ARLEN} + 17'd1) << ARSIZE;
    assign w_end_in = w_bytes + {15'd0, ARADDR[1:0]};
    assign w_over   = w_end_in > 17'd4096;
    assign w_free   = !req_rd_data[0];
    assign w_unused_rd_id = ^req_rd_data[ID_WIDTH:1];

    // Header fields derive from the latched request; end = offset + bytes.
    logic [12:0] w_end_p3;
    logic [10:0] w_len;
    logic        w_one;
    logic [1:0]  w_sh;
    logic [3:0]  w_emask;
    logic [3:0]  w_fbe0;
    logic [3:0]  w_fbe;
    logic [3:0]  w_lbe;
    logic        w_4dw;
    logic [31:0] w_dw0;
    logic [31:0] w_dw1;
    logic [31:0] w_dw2;
    logic [31:0] w_dw3;

    assign w_end_p3 = r_end + 13'd3;
    assign w_len    = w_end_p3[12:2];
    assign w_one    = w_len == 11'd1;
    assign w_sh     = 2'd0 - r_end[1:0];
    assign w_emask  = 4'hF >> w_sh;
    assign w_fbe0   = 4'hF << r_addr[1:0];
    assign w_fbe    = w_one ? (w_fbe0 & w_emask) : w_fbe0;
    assign w_lbe    = w_one ? 4'h0 : w_emask;
    assign w_4dw    = |r_addr[ADDR_WIDTH-1:32];
    assign w_dw0    = {(w_4dw ? 3'b001 : 3'b000), 5'b0, 14'b0, w_len[9:0]};
    assign w_dw1    = {REQUESTER_ID, {(8 - TAG_WIDTH){1'b0}}, r_tag, w_lbe, w_fbe};
    assign w_dw2    = w_4dw ? r_addr[63:32] : {r_addr[31:2], 2'b00};
    assign w_dw3    = w_4dw ? {r_addr[31:2], 2'b00} : 32'h0;

    always_comb begin
        w_next      = r_state;
        req_wr_en   = 1'b0;
        hdr_valid   = 1'b0;
        unique case (r_state)
            S_IDLE:  if (w_accept && !w_over) w_next = S_SCAN;
            S_SCAN:  if (w_free) w_next = S_ALLOC;
            S_ALLOC: begin
                req_wr_en = 1'b1;
                w_next    = S_SEND;
            end
            S_SEND: begin
                hdr_valid = 1'b1;
                if (hdr_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign ARREADY      = r_arready;
    assign req_rd_addr  = r_ptr;
    assign req_wr_addr  = r_tag;
    assign req_wr_data  = {r_id, 1'b1};
    assign hdr          = r_hdr;
    assign hdr_4dw      = r_hdr_4dw;
    assign tags_full    = r_tags_full;
    assign err_oversize = r_err;

    always_ff @(posedge clk) begin
        if (arst) begin
            r_state     <= S_IDLE;
            r_arready   <= 1'b0;
            r_id        <= '0;
            r_addr      <= '0;
            r_end       <= '0;
            r_ptr       <= '0;
            r_tag       <= '0;
            r_next_tag  <= '0;
            r_cnt       <= '0;
            r_tags_full <= 1'b0;
            r_err       <= 1'b0;
            r_hdr       <= '0;
            r_hdr_4dw   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_arready <= w_next == S_IDLE;
            r_err     <= w_accept && w_over;
            unique case (r_state)
                S_IDLE: if (w_accept) begin
                    r_id   <= ARID;
                    r_addr <= ARADDR;
                    r_end  <= w_end_in[12:0];
                    r_ptr  <= r_next_tag;
                    r_cnt  <= '0;
                end
                S_SCAN: if (w_free) begin
                    r_tag       <= r_ptr;
                    r_tags_full <= 1'b0;
                end else begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_cnt != CNT_FULL) r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) r_tags_full <= 1'b1;
                end
                S_ALLOC: begin
                    r_hdr     <= {w_dw0, w_dw1, w_dw2, w_dw3};
                    r_hdr_4dw <= w_4dw;
                end
                S_SEND: if (hdr_ready) r_next_tag <= r_tag + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_a2p_read_request_mapper.sv
// Bench for a2p_read_request_mapper: directed cases plus random ARs
// checked against a transaction-level model; the bench plays the recorder.
module tb_a2p_read_request_mapper;

    localparam int TW    = 4;
    localparam int IDW   = 8;
    localparam int DEPTH = 16;

    logic           clk = 1'b0;
    logic           arst;
    logic           ARVALID;
    logic           ARREADY;
    logic [IDW-1:0] ARID;
    logic [63:0]    ARADDR;
    logic [7:0]     ARLEN;
    logic [2:0]     ARSIZE;
    logic [TW-1:0]  req_rd_addr;
    logic [IDW:0]   req_rd_data;
    logic           req_wr_en;
    logic [TW-1:0]  req_wr_addr;
    logic [IDW:0]   req_wr_data;
    logic           hdr_valid;
    logic           hdr_ready;
    logic [127:0]   hdr;
    logic           hdr_4dw;
    logic           tags_full;
    logic           err_oversize;

    always #5 clk = ~clk;

    a2p_read_request_mapper dut (
        .clk          (clk),
        .arst         (arst),
        .ARVALID      (ARVALID),
        .ARREADY      (ARREADY),
        .ARID         (ARID),
        .ARADDR       (ARADDR),
        .ARLEN        (ARLEN),
        .ARSIZE       (ARSIZE),
        .req_rd_addr  (req_rd_addr),
        .req_rd_data  (req_rd_data),
        .req_wr_en    (req_wr_en),
        .req_wr_addr  (req_wr_addr),
        .req_wr_data  (req_wr_data),
        .hdr_valid    (hdr_valid),
        .hdr_ready    (hdr_ready),
        .hdr          (hdr),
        .hdr_4dw      (hdr_4dw),
        .tags_full    (tags_full),
        .err_oversize (err_oversize)
    );

    // Recorder: 1 = clear all, 2 = set all valid, 3 = clear one entry.
    logic [IDW:0]  mem [DEPTH];
    logic [1:0]    op;
    logic [TW-1:0] op_addr;

    always @(posedge clk) begin
        if (op == 2'd1) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (op == 2'd2) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= {8'(8'hA0 + i), 1'b1};
        end else if (op == 2'd3) begin
            mem[op_addr][0] <= 1'b0;
        end
        if (req_wr_en) mem[req_wr_addr] <= req_wr_data;
    end

    assign req_rd_data = mem[req_rd_addr];

    int n_chk  = 0;
    int n_fail = 0;
    int m_next = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mem_op(input logic [1:0] o, input logic [TW-1:0] a);
        op      = o;
        op_addr = a;
        cyc(1);
        op      = 2'd0;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        cyc(1);
        chk("rst_outs", {ARREADY, req_wr_en, hdr_valid, hdr_4dw,
                         tags_full, err_oversize, req_rd_addr}, '0);
        chk("rst_hdr", hdr, '0);
        arst   = 1'b0;
        m_next = 0;
    endtask

    function automatic bit m_over(input logic [63:0] a, input logic [7:0] len,
                                  input logic [2:0] sz);
        int nb;
        nb = (int'(len) + 1) * (1 << sz);
        return (int'(a[1:0]) + nb) > 4096;
    endfunction

    function automatic int m_tag();
        int k;
        for (int d = 0; d < DEPTH; d++) begin
            k = (m_next + d) % DEPTH;
            if (!mem[k][0]) return k;
        end
        return -1;
    endfunction

    function automatic logic [127:0] m_hdr(input logic [63:0] a,
                                           input logic [7:0] len,
                                           input logic [2:0] sz,
                                           input int tg);
        int          off;
        int          e;
        int          nw;
        bit          four;
        logic [3:0]  fbe;
        logic [3:0]  lbe;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] d3;
        off  = int'(a[1:0]);
        e    = off + (int'(len) + 1) * (1 << sz);
        nw   = (e + 3) / 4;
        four = a[63:32] != 32'h0;
        fbe  = 4'h0;
        lbe  = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < e) fbe[i] = 1'b1;
            if (nw > 1 && (nw - 1) * 4 + i < e) lbe[i] = 1'b1;
        end
        d0 = 32'(nw % 1024);
        if (four) d0 = d0 + 32'h2000_0000;
        d1 = {16'h0100, 8'(tg), lbe, fbe};
        d2 = four ? a[63:32] : {a[31:2], 2'b00};
        d3 = four ? {a[31:2], 2'b00} : 32'h0;
        return {d0, d1, d2, d3};
    endfunction

    // Leaves time at the negedge of the cycle after the AR handshake.
    task automatic send_ar(input logic [7:0] id, input logic [63:0] a,
                           input logic [7:0] len, input logic [2:0] sz);
        int t = 0;
        while (!ARREADY && t < 20) begin
            cyc(1);
            t++;
        end
        chk("ar_ready_wait", 128'(t < 20), 128'd1);
        ARVALID = 1'b1;
        ARID    = id;
        ARADDR  = a;
        ARLEN   = len;
        ARSIZE  = sz;
        cyc(1);
        ARVALID = 1'b0;
    endtask

    task automatic run_ar(input logic [7:0] id, input logic [63:0] a,
                          input logic [7:0] len, input logic [2:0] sz,
                          input int hold, output logic [127:0] got);
        bit           ov;
        int           tg;
        int           c;
        int           quiet;
        logic [127:0] eh;
        ov  = m_over(a, len, sz);
        tg  = m_tag();
        got = '0;
        send_ar(id, a, len, sz);
        if (ov) begin
            chk("err_pulse", 128'(err_oversize), 128'd1);
            chk("ovr_ready", 128'(ARREADY), 128'd1);
            quiet = 0;
            repeat (3) begin
                cyc(1);
                quiet += int'(req_wr_en | hdr_valid | err_oversize);
            end
            chk("ovr_quiet", 128'(quiet), 128'd0);
        end else begin
            c = 1;
            while (!req_wr_en && c < 40) begin
                cyc(1);
                c++;
            end
            chk("wr_lat", 128'(c), 128'(2 + (tg - m_next + DEPTH) % DEPTH));
            chk("wr_addr", 128'(req_wr_addr), 128'(tg));
            chk("wr_data", 128'(req_wr_data), 128'({id, 1'b1}));
            cyc(1);
            eh = m_hdr(a, len, sz, tg);
            chk("hdr_valid", 128'(hdr_valid), 128'd1);
            chk("hdr", hdr, eh);
            chk("hdr_4dw", 128'(hdr_4dw), 128'(a[63:32] != 32'h0));
            got = hdr;
            for (int h = 0; h < hold; h++) begin
                cyc(1);
                chk("hold_hdr", hdr, eh);
                chk("hold_busy", 128'({hdr_valid, ARREADY}), 128'b10);
            end
            hdr_ready = 1'b1;
            cyc(1);
            hdr_ready = 1'b0;
            chk("send_done", 128'({hdr_valid, ARREADY}), 128'b01);
            m_next = (tg + 1) % DEPTH;
        end
    endtask

    logic [127:0] g;
    int           bad;
    int           c;
    int           nvalid;
    logic [63:0]  ra;

    initial begin
        arst      = 1'b1;
        ARVALID   = 1'b0;
        ARID      = '0;
        ARADDR    = '0;
        ARLEN     = '0;
        ARSIZE    = '0;
        hdr_ready = 1'b0;
        op        = 2'd0;
        op_addr   = '0;
        cyc(2);
        mem_op(2'd1, '0);
        do_reset();
        cyc(1);
        chk("idle_ready", 128'(ARREADY), 128'd1);

        // Basic 3DW and 4DW requests
        run_ar(8'h3C, 64'h1000, 8'd3, 3'd2, 0, g);
        chk("t1_hdr", g, 128'h00000004_010000FF_00001000_00000000);
        chk("t1_rec", 128'(mem[0]), 128'({8'h3C, 1'b1}));
        run_ar(8'h11, 64'h1_0000_0002, 8'd0, 3'd1, 0, g);
        chk("t2_hdr", g, 128'h20000001_0100010C_00000001_00000000);

        // Oversize rejects and the 4096-byte boundary
        run_ar(8'h22, 64'h0, 8'd255, 3'd7, 0, g);
        run_ar(8'h23, 64'h1, 8'd255, 3'd4, 0, g);
        run_ar(8'h24, 64'h4000, 8'd255, 3'd4, 0, g);
        run_ar(8'h25, 64'h8003, 8'd1, 3'd0, 0, g);

        // Header backpressure, then back-to-back tags
        do_reset();
        mem_op(2'd1, '0);
        run_ar(8'h31, 64'h2004, 8'd7, 3'd3, 5, g);
        run_ar(8'h32, 64'h3000, 8'd0, 3'd2, 0, g);
        chk("b2b_tag0", 128'(mem[0]), 128'({8'h31, 1'b1}));
        chk("b2b_tag1", 128'(mem[1]), 128'({8'h32, 1'b1}));

        // All tags busy, then entry 9 frees mid-scan
        do_reset();
        mem_op(2'd2, '0);
        send_ar(8'h55, 64'h2000, 8'd0, 3'd2);
        bad = 0;
        repeat (15) begin
            bad += int'(tags_full | req_wr_en);
            cyc(1);
        end
        chk("full_early", 128'(bad + int'(tags_full)), 128'd0);
        cyc(1);
        chk("tags_full", 128'(tags_full), 128'd1);
        chk("full_nowr", 128'(req_wr_en), 128'd0);
        mem_op(2'd3, 4'd9);
        c = 0;
        while (!req_wr_en && c < 40) begin
            cyc(1);
            c++;
        end
        chk("full_lat", 128'(c), 128'd9);
        chk("full_tag", 128'(req_wr_addr), 128'd9);
        chk("full_clr", 128'(tags_full), 128'd0);
        cyc(1);
        hdr_ready = 1'b1;
        cyc(1);
        hdr_ready = 1'b0;

        // Reset during SCAN and during SEND
        send_ar(8'h66, 64'h5000, 8'd0, 3'd2);
        cyc(3);
        do_reset();
        bad = 0;
        repeat (4) begin
            cyc(1);
            bad += int'(req_wr_en);
        end
        chk("scan_abort", 128'(bad), 128'd0);
        mem_op(2'd1, '0);
        run_ar(8'h67, 64'h6000, 8'd0, 3'd2, 0, g);
        send_ar(8'h68, 64'h7000, 8'd0, 3'd2);
        cyc(2);
        chk("pre_rst_send", 128'(hdr_valid), 128'd1);
        do_reset();
        mem_op(2'd1, '0);
        run_ar(8'h69, 64'h7100, 8'd0, 3'd2, 0, g);
        chk("rst_tag0", 128'(mem[0]), 128'({8'h69, 1'b1}));

        // Random traffic with random completions freeing entries
        for (int n = 0; n < 60; n++) begin
            nvalid = 0;
            for (int i = 0; i < DEPTH; i++) nvalid += int'(mem[i][0]);
            if (nvalid == DEPTH || $urandom_range(0, 2) == 0)
                mem_op(2'd3, 4'($urandom_range(0, DEPTH - 1)));
            ra = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) ra[63:32] = 32'h0;
            run_ar(8'($urandom), ra,
                   ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                                : 8'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)), $urandom_range(0, 3), g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
